fetch_pc_queue: RTL and testbench

Fetch-side PC generator and in-flight prediction queue that wraps the next-PC predictor. Each cycle it registers the predicted next PC into `pc_reg`, which the predictor consumes. It also pushes that prediction's metadata into a FIFO. When EX resolves the oldest in-flight instruction, the block pops the FIFO and compares the real target with the predicted one. It then drives `mis_pdc` and the predictor update fields, and redirects `pc_reg` on a mismatch or an external flush.

---
 rtl/fetch_pc_queue.sv | 110 +++++++++++
 tb/tb_fetch_pc_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_queue.sv
// Fetch PC register plus in-flight prediction queue; pc_reg updates 1 cycle after npc/redirect, mis_pdc is same-cycle.
// Push blocks on stall/full/redirect; pop/flush ignore stall. Optional counters under FETCH_PC_QUEUE_STAT_EN.
module fetch_pc_queue #(
   parameter int ADDR_WIDTH = 30,
   parameter int k_width    = 14,
   parameter int DEPTH      = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = 30'h0700_0000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] npc_pdc,
   input  logic                  taken_pdc,
   input  logic [1:0]            choice_pdch,
   input  logic [k_width-1:0]    pc_hashed_reg,
   input  logic                  flush_en,
   input  logic [ADDR_WIDTH-1:0] flush_pc,
   input  logic                  ex_valid,
   input  logic [ADDR_WIDTH-1:0] npc_ex,
   output logic [ADDR_WIDTH-1:0] pc_reg,
   output logic                  push_fire,
   output logic                  q_full,
   output logic                  mis_pdc,
   output logic [k_width-1:0]    pc_ex_hashed,
   output logic [1:0]            choice_pdch_ex,
`ifdef FETCH_PC_QUEUE_STAT_EN
   output logic [31:0]           stat_resolved,
   output logic [31:0]           stat_mispred,
`endif
   output logic                  taken_pdc_ex
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] npc;
      logic                  taken;
      logic [1:0]            choice;
      logic [k_width-1:0]    hashed;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head_ent;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          empty;
   logic          pop;

   assign empty     = (count == '0);
   assign q_full    = (count == FULL_CNT);
   assign pop       = ex_valid && !empty;
   assign head_ent  = mem[head];
   assign mis_pdc   = pop && (head_ent.npc != npc_ex);
   assign push_fire = !stall && !q_full && !flush_en && !mis_pdc && rstn;

   // Storage is never read while empty, so the head fields are masked instead of resetting the array.
   assign pc_ex_hashed   = empty ? '0 : head_ent.hashed;
   assign choice_pdch_ex = empty ? '0 : head_ent.choice;
   assign taken_pdc_ex   = empty ? 1'b0 : head_ent.taken;

   always_ff @(posedge clk) begin
      if (push_fire)
         mem[tail] <= '{npc: npc_pdc, taken: taken_pdc, choice: choice_pdch, hashed: pc_hashed_reg};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_reg <= RESET_PC;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else if (flush_en) begin
         pc_reg <= flush_pc;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else if (mis_pdc) begin
         pc_reg <= npc_ex;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else begin
         if (push_fire) begin
            pc_reg <= npc_pdc;
            tail   <= tail + 1'b1;
         end
         if (pop)
            head <= head + 1'b1;
         count <= count + (PW+1)'(push_fire) - (PW+1)'(pop);
      end
   end

`ifdef FETCH_PC_QUEUE_STAT_EN
   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else begin
         if (pop && (stat_resolved != 32'hFFFF_FFFF))
            stat_resolved <= stat_resolved + 32'd1;
         if (mis_pdc && (stat_mispred != 32'hFFFF_FFFF))
            stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue: reset, fill/backpressure, resolve, flush priority, empty pop, wrap, stats.
module tb_fetch_pc_queue;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic [29:0] npc_pdc;
   logic        taken_pdc;
   logic [1:0]  choice_pdch;
   logic [13:0] pc_hashed_reg;
   logic        flush_en;
   logic [29:0] flush_pc;
   logic        ex_valid;
   logic [29:0] npc_ex;
   logic [29:0] pc_reg;
   logic        push_fire;
   logic        q_full;
   logic        mis_pdc;
   logic [13:0] pc_ex_hashed;
   logic [1:0]  choice_pdch_ex;
   logic        taken_pdc_ex;
`ifdef FETCH_PC_QUEUE_STAT_EN
   logic [31:0] stat_resolved;
   logic [31:0] stat_mispred;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_pc_queue dut (
      .clk(clk), .rstn(rstn), .stall(stall), .npc_pdc(npc_pdc), .taken_pdc(taken_pdc),
      .choice_pdch(choice_pdch), .pc_hashed_reg(pc_hashed_reg), .flush_en(flush_en),
      .flush_pc(flush_pc), .ex_valid(ex_valid), .npc_ex(npc_ex), .pc_reg(pc_reg),
      .push_fire(push_fire), .q_full(q_full), .mis_pdc(mis_pdc), .pc_ex_hashed(pc_ex_hashed),
      .choice_pdch_ex(choice_pdch_ex),
`ifdef FETCH_PC_QUEUE_STAT_EN
      .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
      .taken_pdc_ex(taken_pdc_ex)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entries carry taken = hash[0], choice = hash[2:1] so the head fields are predictable.
   task automatic push_one(input logic [29:0] npc, input logic [13:0] hash);
      stall         = 1'b0;
      npc_pdc       = npc;
      pc_hashed_reg = hash;
      taken_pdc     = hash[0];
      choice_pdch   = hash[2:1];
      tick();
      stall = 1'b1;
   endtask

   task automatic clear_queue();
      flush_en = 1'b1;
      flush_pc = 30'h0700_0000;
      tick();
      flush_en = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; stall = 1'b1; flush_en = 1'b0; flush_pc = '0; ex_valid = 1'b0; npc_ex = '0;
      npc_pdc = '0; taken_pdc = 1'b0; choice_pdch = '0; pc_hashed_reg = '0;
      tick(); tick();
      n_cmp++; if (pc_reg !== 30'h0700_0000) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc_reg, 30'h0700_0000); end
      n_cmp++; if (q_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", q_full); end
      n_cmp++; if (push_fire !== 1'b0) begin n_bad++; $display("FAIL reset_push: got %b want 0", push_fire); end
      n_cmp++; if (pc_ex_hashed !== 14'h0) begin n_bad++; $display("FAIL reset_head: got %h want 0", pc_ex_hashed); end
      stall = 1'b0; npc_pdc = 30'h0700_0002; pc_hashed_reg = 14'h5; taken_pdc = 1'b1; choice_pdch = 2'd2;
      rstn = 1'b1;
      #1;
      n_cmp++; if (push_fire !== 1'b1) begin n_bad++; $display("FAIL release_push: got %b want 1", push_fire); end
      tick();
      stall = 1'b1;
      n_cmp++; if (pc_reg !== 30'h0700_0002) begin n_bad++; $display("FAIL first_pc: got %h want %h", pc_reg, 30'h0700_0002); end
      n_cmp++; if (pc_ex_hashed !== 14'h5) begin n_bad++; $display("FAIL first_head_hash: got %h want 5", pc_ex_hashed); end
      n_cmp++; if (taken_pdc_ex !== 1'b1) begin n_bad++; $display("FAIL first_head_taken: got %b want 1", taken_pdc_ex); end
      n_cmp++; if (choice_pdch_ex !== 2'd2) begin n_bad++; $display("FAIL first_head_choice: got %0d want 2", choice_pdch_ex); end
   endtask

   task automatic test_full();
      clear_queue();
      for (int i = 0; i < 8; i++) push_one(30'h0700_0010 + 30'(i), 14'h10 + 14'(i));
      stall = 1'b0; npc_pdc = 30'h0700_0099; pc_hashed_reg = 14'h99;
      #1;
      n_cmp++; if (q_full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", q_full); end
      n_cmp++; if (push_fire !== 1'b0) begin n_bad++; $display("FAIL full_push: got %b want 0", push_fire); end
      tick();
      n_cmp++; if (pc_reg !== 30'h0700_0017) begin n_bad++; $display("FAIL full_pc_hold: got %h want %h", pc_reg, 30'h0700_0017); end
      ex_valid = 1'b1; npc_ex = 30'h0700_0010;
      #1;
      n_cmp++; if (mis_pdc !== 1'b0) begin n_bad++; $display("FAIL full_pop_mis: got %b want 0", mis_pdc); end
      n_cmp++; if (push_fire !== 1'b0) begin n_bad++; $display("FAIL full_pop_push: got %b want 0", push_fire); end
      n_cmp++; if (pc_ex_hashed !== 14'h10) begin n_bad++; $display("FAIL full_head: got %h want 10", pc_ex_hashed); end
      tick();
      ex_valid = 1'b0;
      #1;
      n_cmp++; if (q_full !== 1'b0) begin n_bad++; $display("FAIL after_pop_full: got %b want 0", q_full); end
      n_cmp++; if (push_fire !== 1'b1) begin n_bad++; $display("FAIL after_pop_push: got %b want 1", push_fire); end
      n_cmp++; if (pc_ex_hashed !== 14'h11) begin n_bad++; $display("FAIL after_pop_head: got %h want 11", pc_ex_hashed); end
      tick();
      stall = 1'b1;
      n_cmp++; if (pc_reg !== 30'h0700_0099) begin n_bad++; $display("FAIL resume_pc: got %h want %h", pc_reg, 30'h0700_0099); end
      n_cmp++; if (q_full !== 1'b1) begin n_bad++; $display("FAIL refull: got %b want 1", q_full); end
   endtask

   task automatic test_mispredict();
      clear_queue();
      push_one(30'h0700_0010, 14'h20);
      push_one(30'h0700_0010, 14'h21);
      ex_valid = 1'b1; npc_ex = 30'h0700_0010;
      #1;
      n_cmp++; if (mis_pdc !== 1'b0) begin n_bad++; $display("FAIL hit_mis: got %b want 0", mis_pdc); end
      tick();
      n_cmp++; if (pc_ex_hashed !== 14'h21) begin n_bad++; $display("FAIL hit_pop_head: got %h want 21", pc_ex_hashed); end
      npc_ex = 30'h0700_0020;
      #1;
      n_cmp++; if (mis_pdc !== 1'b1) begin n_bad++; $display("FAIL miss_mis: got %b want 1", mis_pdc); end
      tick();
      ex_valid = 1'b0;
      #1;
      n_cmp++; if (pc_reg !== 30'h0700_0020) begin n_bad++; $display("FAIL miss_redirect: got %h want %h", pc_reg, 30'h0700_0020); end
      n_cmp++; if (pc_ex_hashed !== 14'h0) begin n_bad++; $display("FAIL miss_empty: got %h want 0", pc_ex_hashed); end
   endtask

   task automatic test_flush_priority();
      push_one(30'h0700_0030, 14'h30);
      ex_valid = 1'b1; npc_ex = 30'h0700_0040; flush_en = 1'b1; flush_pc = 30'h0000_0100;
      #1;
      n_cmp++; if (mis_pdc !== 1'b1) begin n_bad++; $display("FAIL flush_mis: got %b want 1", mis_pdc); end
      tick();
      flush_en = 1'b0; ex_valid = 1'b0;
      #1;
      n_cmp++; if (pc_reg !== 30'h0000_0100) begin n_bad++; $display("FAIL flush_pc: got %h want %h", pc_reg, 30'h0000_0100); end
      n_cmp++; if (pc_ex_hashed !== 14'h0) begin n_bad++; $display("FAIL flush_empty: got %h want 0", pc_ex_hashed); end
   endtask

   task automatic test_empty_ex();
      ex_valid = 1'b1; npc_ex = 30'h0000_0123;
      #1;
      n_cmp++; if (mis_pdc !== 1'b0) begin n_bad++; $display("FAIL empty_mis: got %b want 0", mis_pdc); end
      tick();
      ex_valid = 1'b0;
      n_cmp++; if (pc_reg !== 30'h0000_0100) begin n_bad++; $display("FAIL empty_pc: got %h want %h", pc_reg, 30'h0000_0100); end
      n_cmp++; if (pc_ex_hashed !== 14'h0) begin n_bad++; $display("FAIL empty_head: got %h want 0", pc_ex_hashed); end
      push_one(30'h0700_0050, 14'h3F);
      n_cmp++; if (pc_ex_hashed !== 14'h3F) begin n_bad++; $display("FAIL empty_then_push: got %h want 3f", pc_ex_hashed); end
   endtask

   task automatic test_wrap();
      logic [43:0] model[$];
      logic [29:0] nn;
      logic [13:0] hh;
      logic [13:0] eh;
      model.push_back({30'h0700_0050, 14'h3F});
      for (int i = 0; i < 20; i++) begin
         nn = 30'h0700_1000 + 30'(i);
         hh = 14'h100 + 14'(i);
         eh = model[0][13:0];
         stall = 1'b0; npc_pdc = nn; pc_hashed_reg = hh; taken_pdc = hh[0]; choice_pdch = hh[2:1];
         ex_valid = 1'b1; npc_ex = model[0][43:14];
         #1;
         n_cmp++; if (mis_pdc !== 1'b0) begin n_bad++; $display("FAIL wrap_mis[%0d]: got %b want 0", i, mis_pdc); end
         n_cmp++; if (push_fire !== 1'b1) begin n_bad++; $display("FAIL wrap_push[%0d]: got %b want 1", i, push_fire); end
         n_cmp++; if ({pc_ex_hashed, taken_pdc_ex, choice_pdch_ex} !== {eh, eh[0], eh[2:1]}) begin
            n_bad++; $display("FAIL wrap_head[%0d]: got %h/%b/%0d want %h/%b/%0d", i, pc_ex_hashed, taken_pdc_ex, choice_pdch_ex, eh, eh[0], eh[2:1]);
         end
         void'(model.pop_front());
         model.push_back({nn, hh});
         tick();
         n_cmp++; if (pc_reg !== nn) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, pc_reg, nn); end
      end
      stall = 1'b1; ex_valid = 1'b0;
      #1;
      n_cmp++; if (pc_ex_hashed !== 14'h113) begin n_bad++; $display("FAIL wrap_final_head: got %h want 113", pc_ex_hashed); end
   endtask

   task automatic test_async_reset();
      rstn = 1'b0;
      #1;
      n_cmp++; if (pc_reg !== 30'h0700_0000) begin n_bad++; $display("FAIL areset_pc: got %h want %h", pc_reg, 30'h0700_0000); end
      n_cmp++; if (pc_ex_hashed !== 14'h0) begin n_bad++; $display("FAIL areset_head: got %h want 0", pc_ex_hashed); end
      n_cmp++; if (push_fire !== 1'b0) begin n_bad++; $display("FAIL areset_push: got %b want 0", push_fire); end
      stall = 1'b0; npc_pdc = 30'h0700_0004; pc_hashed_reg = 14'h7; taken_pdc = 1'b1; choice_pdch = 2'd3;
      rstn = 1'b1;
      #1;
      n_cmp++; if (push_fire !== 1'b1) begin n_bad++; $display("FAIL arelease_push: got %b want 1", push_fire); end
      tick();
      stall = 1'b1;
      n_cmp++; if (pc_reg !== 30'h0700_0004) begin n_bad++; $display("FAIL arelease_pc: got %h want %h", pc_reg, 30'h0700_0004); end
      n_cmp++; if (pc_ex_hashed !== 14'h7) begin n_bad++; $display("FAIL arelease_head: got %h want 7", pc_ex_hashed); end
   endtask

`ifdef FETCH_PC_QUEUE_STAT_EN
   task automatic resolve(input logic [29:0] v);
      ex_valid = 1'b1;
      npc_ex   = v;
      tick();
      ex_valid = 1'b0;
   endtask

   task automatic test_stats();
      rstn = 1'b0;
      #1;
      n_cmp++; if (stat_resolved !== 32'd0) begin n_bad++; $display("FAIL stat_reset_res: got %0d want 0", stat_resolved); end
      rstn = 1'b1;
      push_one(30'h0700_0200, 14'h1);
      push_one(30'h0700_0204, 14'h2);
      push_one(30'h0700_0208, 14'h3);
      resolve(30'h0700_0200);
      resolve(30'h0700_0204);
      resolve(30'h0700_0300);
      push_one(30'h0700_020C, 14'h4);
      push_one(30'h0700_0210, 14'h5);
      resolve(30'h0700_020C);
      resolve(30'h0700_0999);
      resolve(30'h0700_0999);
      n_cmp++; if (stat_resolved !== 32'd5) begin n_bad++; $display("FAIL stat_resolved: got %0d want 5", stat_resolved); end
      n_cmp++; if (stat_mispred !== 32'd2) begin n_bad++; $display("FAIL stat_mispred: got %0d want 2", stat_mispred); end
   endtask
`endif

   initial begin
      test_reset();
      test_full();
      test_mispredict();
      test_flush_priority();
      test_empty_ex();
      test_wrap();
      test_async_reset();
`ifdef FETCH_PC_QUEUE_STAT_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
